// File: rtl/regfile_read.sv
// Two-read, one-write register file with a hardwired zero register at index 31
// and same-cycle write-to-read bypass so decode sees the value being written back.
module regfile_read #(
  parameter int N     = 64,
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         write_en,
  input  logic [4:0]   write_reg,
  input  logic [N-1:0] write_data,
  input  logic [4:0]   read_reg1,
  input  logic [4:0]   read_reg2,
  output logic [N-1:0] read_data1,
  output logic [N-1:0] read_data2
);

  localparam int         NSTORE   = DEPTH - 1;
  localparam logic [4:0] ZERO_REG = 5'(DEPTH - 1);

  logic [N-1:0]      storage_q [NSTORE];
  logic [NSTORE-1:0] wr_en_d;
  logic              wr_live;
  logic              bypass1;
  logic              bypass2;
  logic [N-1:0]      stored1;
  logic [N-1:0]      stored2;

  // One-hot write decode; index 31 never matches, so zero-register writes vanish.
  always_comb begin
    wr_en_d = '0;
    for (int i = 0; i < NSTORE; i++) begin
      wr_en_d[i] = write_en && (write_reg == 5'(i));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NSTORE; i++) begin
      if (reset) begin
        storage_q[i] <= '0;
      end else if (wr_en_d[i]) begin
        storage_q[i] <= write_data;
      end
    end
  end

  // Storage lookup; an unmatched index (31) falls through to zero.
  always_comb begin
    stored1 = '0;
    stored2 = '0;
    for (int i = 0; i < NSTORE; i++) begin
      if (read_reg1 == 5'(i)) stored1 = storage_q[i];
      if (read_reg2 == 5'(i)) stored2 = storage_q[i];
    end
  end

  // Bypass only for a write that will actually land at the coming edge.
  assign wr_live = !reset && write_en && (write_reg != ZERO_REG);
  assign bypass1 = wr_live && (write_reg == read_reg1);
  assign bypass2 = wr_live && (write_reg == read_reg2);

  assign read_data1 = bypass1 ? write_data : stored1;
  assign read_data2 = bypass2 ? write_data : stored2;

endmodule

// File: tb/tb_regfile_read.sv
// Bench for regfile_read: reset sweep, walking-one fill, a vector table of
// zero-register/bypass/hold cases, random traffic against a model, and reset-over-write.
module tb_regfile_read;

  localparam int N = 64;

  typedef struct {
    logic         we;
    logic [4:0]   wr;
    logic [N-1:0] wd;
    logic [4:0]   r1;
    logic [4:0]   r2;
    logic [N-1:0] e1;
    logic [N-1:0] e2;
  } vec_t;

  logic         clk;
  logic         reset;
  logic         write_en;
  logic [4:0]   write_reg;
  logic [N-1:0] write_data;
  logic [4:0]   read_reg1;
  logic [4:0]   read_reg2;
  logic [N-1:0] read_data1;
  logic [N-1:0] read_data2;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] mdl [32];
  int           n_checks;
  int           n_pass;

  regfile_read #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .write_en   (write_en),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic [4:0] wr,
                       input logic [N-1:0] wd, input logic [4:0] r1, input logic [4:0] r2);
    reset      = rst;
    write_en   = we;
    write_reg  = wr;
    write_data = wd;
    read_reg1  = r1;
    read_reg2  = r2;
  endtask

  // Apply one cycle: push expectations, compare mid-cycle, then take the edge
  // and advance the reference model.
  task automatic step(input string name, input logic rst, input logic we, input logic [4:0] wr,
                      input logic [N-1:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [N-1:0] e1, input logic [N-1:0] e2);
    drive(rst, we, wr, wd, r1, r2);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    @(negedge clk);
    compare({name, ".rd1"}, read_data1, exp_q.pop_front());
    compare({name, ".rd2"}, read_data2, exp_q.pop_front());
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 32; k++) mdl[k] = '0;
    end else if (we && wr != 5'd31) begin
      mdl[wr] = wd;
    end
    #1;
  endtask

  function automatic logic [N-1:0] model_read(input logic we, input logic [4:0] wr,
                                              input logic [N-1:0] wd, input logic [4:0] r);
    if (r == 5'd31) return '0;
    if (we && wr == r) return wd;
    return mdl[r];
  endfunction

  vec_t vecs [12];

  initial begin
    logic         we;
    logic [4:0]   wr;
    logic [4:0]   r1;
    logic [4:0]   r2;
    logic [N-1:0] wd;
    logic [N-1:0] one;

    n_checks = 0;
    n_pass   = 0;
    one      = 64'h1;
    for (int k = 0; k < 32; k++) mdl[k] = '0;

    vecs[0]  = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd4,  64'h0,  one << 4};
    vecs[1]  = '{1'b0, 5'd0,  64'h0,                   5'd31, 5'd30, 64'h0,  one << 30};
    vecs[2]  = '{1'b0, 5'd0,  64'h0,                   5'd0,  5'd29, one,    one << 29};
    vecs[3]  = '{1'b1, 5'd5,  64'hA,                   5'd0,  5'd1,  one,    one << 1};
    vecs[4]  = '{1'b1, 5'd5,  64'hB,                   5'd5,  5'd5,  64'hB,  64'hB};
    vecs[5]  = '{1'b0, 5'd0,  64'h0,                   5'd5,  5'd6,  64'hB,  one << 6};
    vecs[6]  = '{1'b0, 5'd7,  64'hDEAD,                5'd7,  5'd7,  one << 7, one << 7};
    vecs[7]  = '{1'b0, 5'd0,  64'h0,                   5'd7,  5'd8,  one << 7, one << 8};
    vecs[8]  = '{1'b1, 5'd9,  64'h99,                  5'd9,  5'd10, 64'h99, one << 10};
    vecs[9]  = '{1'b1, 5'd12, 64'hC,                   5'd11, 5'd12, one << 11, 64'hC};
    vecs[10] = '{1'b0, 5'd0,  64'h0,                   5'd12, 5'd9,  64'hC,  64'h99};
    vecs[11] = '{1'b1, 5'd31, 64'h1234,                5'd31, 5'd31, 64'h0,  64'h0};

    // Two reset edges with a write pending; contents undefined before this.
    drive(1'b1, 1'b1, 5'd2, 64'hFACE, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 32; i++) begin
      step("reset_sweep", 1'b0, 1'b0, 5'd0, 64'h0, 5'(i), 5'(31 - i), 64'h0, 64'h0);
    end

    // Walking-one fill; port 1 sees the bypassed value, port 2 the zero register.
    for (int i = 0; i < 31; i++) begin
      step("fill_bypass", 1'b0, 1'b1, 5'(i), one << i, 5'(i), 5'd31, one << i, 64'h0);
    end
    for (int i = 0; i < 32; i++) begin
      step("fill_read", 1'b0, 1'b0, 5'd0, 64'h0, 5'(i), 5'(i),
           (i == 31) ? 64'h0 : one << i, (i == 31) ? 64'h0 : one << i);
    end

    for (int v = 0; v < 12; v++) begin
      step($sformatf("vec%0d", v), 1'b0, vecs[v].we, vecs[v].wr, vecs[v].wd,
           vecs[v].r1, vecs[v].r2, vecs[v].e1, vecs[v].e2);
    end
    step("zero_wr_side", 1'b0, 1'b0, 5'd0, 64'h0, 5'd30, 5'd0, one << 30, one);

    for (int t = 0; t < 200; t++) begin
      we = 1'($urandom_range(0, 1));
      wr = 5'($urandom_range(0, 31));
      wd = {$urandom, $urandom};
      r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      step("random", 1'b0, we, wr, wd, r1, r2,
           model_read(we, wr, wd, r1), model_read(we, wr, wd, r2));
    end

    for (int i = 0; i < 31; i++) begin
      step("repop", 1'b0, 1'b1, 5'(i), 64'(i * 3 + 1), 5'd31, 5'd31, 64'h0, 64'h0);
    end

    // Reset wins over the write; no bypass while reset is high.
    step("rst_cycle", 1'b1, 1'b1, 5'd3, 64'h55, 5'd3, 5'd4, 64'd10, 64'd13);
    for (int i = 0; i < 32; i++) begin
      step("post_rst", 1'b0, 1'b0, 5'd3, 64'h55, 5'(i), 5'(i), 64'h0, 64'h0);
    end
    step("resume_wr", 1'b0, 1'b1, 5'd3, 64'h55, 5'd4, 5'd3, 64'h0, 64'h55);
    step("resume_rd", 1'b0, 1'b0, 5'd0, 64'h0, 5'd3, 5'd4, 64'h55, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
